// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg
// Shared definitions for the SPI block sequencer: the byte width, the FSM
// state encoding and a small elaboration-time helper for sizing counters.
// No ports.

package spi_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STORE  = 3'd3,
    ST_GAP    = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// spi_edge_detect
// Registered rising-edge detector. The previous value of sig is held in a
// flop and rise is high for the one cycle in which sig is 1 and was 0.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset (previous value cleared to 0)
//   sig    in   level to watch
//   rise   out  sig & ~sig_prev

module spi_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_prev;

  always_ff @(posedge clk) begin
    if (reset) sig_prev <= 1'b0;
    else       sig_prev <= sig;
  end

  assign rise = sig & ~sig_prev;

endmodule

// File: rtl/spi_block_sequencer.sv
// spi_block_sequencer
// Exchanges a NUM_BYTES block with a byte-wide SPI master, MSB byte first,
// one start/done handshake per byte. The received bytes are assembled and
// presented on rx_block together with a one-cycle done pulse.
// Optional feature macro: SPI_TIMEOUT_EN -- when defined, a WAIT that lasts
// TIMEOUT_CYCLES cycles without a spi_done edge aborts the block and pulses
// err; when undefined WAIT blocks indefinitely and err is tied 0.
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   req           in   start a block transfer (sampled in IDLE only)
//   tx_block      in   block to send, byte 0 in the MSBs
//   busy          out  transfer in progress
//   done          out  one-cycle pulse, rx_block valid
//   rx_block      out  received block, first byte in the MSBs
//   spi_start     out  master start
//   spi_data_in   out  byte to master
//   spi_busy      in   master busy (status only)
//   spi_done      in   master done, level or pulse
//   spi_data_out  in   byte from master, valid at the spi_done rising edge
//   err           out  timeout pulse
//
// state  | meaning
// IDLE   | waiting for req; block latched on acceptance
// START  | spi_start high for START_HOLD cycles
// WAIT   | waiting for a spi_done rising edge
// STORE  | shift received byte in, advance tx byte and byte count
// GAP    | GAP_CYCLES idle cycles before the next byte
// FINISH | publish rx_block and pulse done

module spi_block_sequencer
  import spi_seq_pkg::*;
#(
  parameter int NUM_BYTES      = 16,
  parameter int START_HOLD     = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req,
  input  logic [NUM_BYTES*BYTE_W-1:0] tx_block,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_BYTES*BYTE_W-1:0] rx_block,
  output logic                        spi_start,
  output logic [BYTE_W-1:0]           spi_data_in,
  input  logic                        spi_busy,
  input  logic                        spi_done,
  input  logic [BYTE_W-1:0]           spi_data_out,
  output logic                        err
);

  localparam int BLK_W   = NUM_BYTES * BYTE_W;
  localparam int CNT_W   = $clog2(NUM_BYTES + 1);
  localparam int TMR_MAX = max3(START_HOLD, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t             state;
  state_t             state_nxt;
  logic [BLK_W-1:0]   tx_sh;
  logic [BLK_W-1:0]   rx_sh;
  logic [BYTE_W-1:0]  rx_byte;
  logic [CNT_W-1:0]   byte_cnt;
  logic [TMR_W-1:0]   tmr;
  logic               done_rise;
  logic               last_byte;
  logic               timeout;

  logic unused_spi_busy;
  assign unused_spi_busy = spi_busy;

  spi_edge_detect u_done_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (spi_done),
    .rise  (done_rise)
  );

  // One down-counter serves START hold, GAP length and the WAIT timeout;
  // it is loaded with (length-1) on entry to a state and expires at zero.
  function automatic logic [TMR_W-1:0] tmr_load(input state_t s);
    logic [TMR_W-1:0] v;
    v = '0;
    case (s)
      ST_START: v = TMR_W'(START_HOLD - 1);
      ST_GAP:   v = (GAP_CYCLES > 0) ? TMR_W'(GAP_CYCLES - 1) : '0;
`ifdef SPI_TIMEOUT_EN
      ST_WAIT:  v = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
      default:  v = '0;
    endcase
    return v;
  endfunction

  assign last_byte = (byte_cnt == CNT_W'(NUM_BYTES - 1));

`ifdef SPI_TIMEOUT_EN
  assign timeout = (state == ST_WAIT) && !done_rise && (tmr == '0);
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req) state_nxt = ST_START;
      ST_START: begin
        // an early done edge still completes the byte
        if (done_rise)      state_nxt = ST_STORE;
        else if (tmr == '0) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise)    state_nxt = ST_STORE;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_STORE: begin
        if (last_byte)            state_nxt = ST_FINISH;
        else if (GAP_CYCLES == 0) state_nxt = ST_START;
        else                      state_nxt = ST_GAP;
      end
      ST_GAP:    if (tmr == '0) state_nxt = ST_START;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state != ST_IDLE);
    spi_start = (state == ST_START);
  end

  assign spi_data_in = tx_sh[BLK_W-1 -: BYTE_W];

  always_ff @(posedge clk) begin
    if (reset)                  tmr <= '0;
    else if (state_nxt != state) tmr <= tmr_load(state_nxt);
    else if (tmr != '0)          tmr <= tmr - TMR_W'(1);
  end

  // Data path: the byte is captured at the done edge itself so a master that
  // only holds data_out for that cycle is still sampled correctly.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_byte  <= '0;
      byte_cnt <= '0;
      rx_block <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            tx_sh    <= tx_block;
            rx_sh    <= '0;
            byte_cnt <= '0;
          end
        end
        ST_START, ST_WAIT: begin
          if (done_rise) rx_byte <= spi_data_out;
        end
        ST_STORE: begin
          rx_sh    <= {rx_sh[BLK_W-BYTE_W-1:0], rx_byte};
          tx_sh    <= {tx_sh[BLK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
        ST_FINISH: begin
          rx_block <= rx_sh;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else       err <= timeout;
  end
`else
  assign err = 1'b0;
`endif

endmodule
